// File: rtl/ysyx_22041071_mem_arbiter_if.sv
// Request/response bundle between the IF/MEM requesters, the arbiter and the AXI bridge cpu_* port.
// The slave modport is the arbiter; the master modport is the requester/bridge side.
interface ysyx_22041071_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic [LEN_W-1:0]  if_req_len;
    logic [1:0]        if_req_size;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic [1:0]        if_rsp_resp;
    logic              if_rsp_last;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LEN_W-1:0]  mem_req_len;
    logic [1:0]        mem_req_size;
    logic              mem_req_we;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic [1:0]        mem_rsp_resp;
    logic              mem_rsp_last;

    logic              cpu_ar_valid;
    logic              cpu_aw_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [LEN_W-1:0]  cpu_len;
    logic [1:0]        cpu_size;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ar_ready;
    logic              cpu_r_valid;
    logic [DATA_W-1:0] cpu_r_data;
    logic [1:0]        cpu_resp;
    logic              cpu_aw_ready;

    modport slave (
        input  if_req_valid, if_req_addr, if_req_len, if_req_size,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
        input  mem_req_valid, mem_req_addr, mem_req_len, mem_req_size, mem_req_we, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp, mem_rsp_last,
        output cpu_ar_valid, cpu_aw_valid, cpu_addr, cpu_len, cpu_size, cpu_data,
        input  cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_resp, cpu_aw_ready
    );

    modport master (
        output if_req_valid, if_req_addr, if_req_len, if_req_size,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp, if_rsp_last,
        output mem_req_valid, mem_req_addr, mem_req_len, mem_req_size, mem_req_we, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp, mem_rsp_last,
        input  cpu_ar_valid, cpu_aw_valid, cpu_addr, cpu_len, cpu_size, cpu_data,
        output cpu_ar_ready, cpu_r_valid, cpu_r_data, cpu_resp, cpu_aw_ready
    );
endinterface

// File: rtl/ysyx_22041071_mem_arbiter.sv
// Round-robin arbiter sharing the AXI bridge cpu_* port between IF (read) and MEM (read/write).
// One transaction in flight; read beats and write completion are routed back to the owner.
module ysyx_22041071_mem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
) (
    input logic                      clk,
    input logic                      reset_n,
    ysyx_22041071_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRdAddr, StRdData, StWrAddr} state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic              last_grant_q;  // 1 = MEM
    logic              owner_q;       // 1 = MEM
    logic              if_ready_q;
    logic              mem_ready_q;
    logic              ar_valid_q;
    logic              aw_valid_q;

    logic grant_any;
    logic grant_mem;
    logic rd_beat;
    logic rd_last;
    logic rd_if;
    logic rd_mem;
    logic wr_done;

    always_comb begin
        grant_any = bus.if_req_valid | bus.mem_req_valid;
        // On a tie MEM wins unless it was granted last.
        grant_mem = bus.mem_req_valid & (~bus.if_req_valid | ~last_grant_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b0;
            owner_q      <= 1'b0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            ar_valid_q   <= 1'b0;
            aw_valid_q   <= 1'b0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        last_grant_q <= grant_mem;
                        owner_q      <= grant_mem;
                        beat_cnt_q   <= '0;
                        if (grant_mem) begin
                            mem_ready_q <= 1'b1;
                            addr_q      <= bus.mem_req_addr;
                            size_q      <= bus.mem_req_size;
                            wdata_q     <= bus.mem_req_wdata;
                            if (bus.mem_req_we) begin
                                len_q      <= '0;
                                aw_valid_q <= 1'b1;
                                state_q    <= StWrAddr;
                            end else begin
                                len_q      <= bus.mem_req_len;
                                ar_valid_q <= 1'b1;
                                state_q    <= StRdAddr;
                            end
                        end else begin
                            if_ready_q <= 1'b1;
                            addr_q     <= bus.if_req_addr;
                            len_q      <= bus.if_req_len;
                            size_q     <= bus.if_req_size;
                            wdata_q    <= '0;
                            ar_valid_q <= 1'b1;
                            state_q    <= StRdAddr;
                        end
                    end
                end
                StRdAddr: begin
                    if (bus.cpu_ar_ready) begin
                        ar_valid_q <= 1'b0;
                        beat_cnt_q <= '0;
                        state_q    <= StRdData;
                    end
                end
                StRdData: begin
                    if (bus.cpu_r_valid) begin
                        if (beat_cnt_q == len_q) begin
                            state_q <= StIdle;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                StWrAddr: begin
                    if (bus.cpu_aw_ready) begin
                        aw_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Responses pass straight through from the bridge; non-owner and idle outputs stay zero.
    always_comb begin
        rd_beat = (state_q == StRdData) & bus.cpu_r_valid;
        rd_last = (beat_cnt_q == len_q);
        rd_if   = rd_beat & ~owner_q;
        rd_mem  = rd_beat & owner_q;
        wr_done = (state_q == StWrAddr) & bus.cpu_aw_ready;
    end

    assign bus.if_req_ready  = if_ready_q;
    assign bus.if_rsp_valid  = rd_if;
    assign bus.if_rsp_data   = rd_if ? bus.cpu_r_data : '0;
    assign bus.if_rsp_resp   = rd_if ? bus.cpu_resp : 2'b00;
    assign bus.if_rsp_last   = rd_if & rd_last;

    assign bus.mem_req_ready = mem_ready_q;
    assign bus.mem_rsp_valid = rd_mem | wr_done;
    assign bus.mem_rsp_data  = rd_mem ? bus.cpu_r_data : '0;
    assign bus.mem_rsp_resp  = (rd_mem | wr_done) ? bus.cpu_resp : 2'b00;
    assign bus.mem_rsp_last  = (rd_mem & rd_last) | wr_done;

    assign bus.cpu_ar_valid  = ar_valid_q;
    assign bus.cpu_aw_valid  = aw_valid_q;
    assign bus.cpu_addr      = addr_q;
    assign bus.cpu_len       = len_q;
    assign bus.cpu_size      = size_q;
    assign bus.cpu_data      = wdata_q;

endmodule

// File: tb/tb_ysyx_22041071_mem_arbiter.sv
// Bench for the IF/MEM bridge arbiter: a transaction table plus hand-written arbitration and
// reset sequences; every response beat is predicted into a scoreboard queue when driven.
module tb_ysyx_22041071_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22041071_mem_arbiter_if bus ();

    ysyx_22041071_mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;    // beat b returns rdata + b
        logic [1:0]  resp;     // response on beat 0 (or on write completion)
        int          delay;    // cycles before ar_ready / aw_ready
        int          gap;      // idle cycles before each read beat
        logic [7:0]  exp_len;  // cpu_len the bridge must see
    } vec_t;

    typedef struct {
        bit          owner;    // 1 = MEM
        logic [63:0] data;
        logic [1:0]  resp;
        bit          last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    vec_t vm;
    vec_t vi;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic gi;
    logic gm;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.cpu_ar_valid && bus.cpu_aw_valid) begin
            n_fail++;
            $display("FAIL ar_aw_exclusive: got both valid, expected at most one");
        end
        if (bus.if_rsp_valid || bus.mem_rsp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got if=%0b mem=%0b, expected no response",
                         bus.if_rsp_valid, bus.mem_rsp_valid);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_mem_valid", bus.mem_rsp_valid, mon_e.owner);
                check("rsp_if_valid", bus.if_rsp_valid, !mon_e.owner);
                check("rsp_data", mon_e.owner ? bus.mem_rsp_data : bus.if_rsp_data, mon_e.data);
                check("rsp_resp", mon_e.owner ? bus.mem_rsp_resp : bus.if_rsp_resp, mon_e.resp);
                check("rsp_last", mon_e.owner ? bus.mem_rsp_last : bus.if_rsp_last, mon_e.last);
            end
        end
    end

    task automatic wait_grant(output logic g_if, output logic g_mem);
        bit done = 0;
        g_if  = 0;
        g_mem = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.if_req_ready || bus.mem_req_ready) begin
                g_if  = bus.if_req_ready;
                g_mem = bus.mem_req_ready;
                done  = 1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout: got no req_ready, expected one within 50 cycles");
        end
    endtask

    task automatic set_req(input vec_t v);
        if (v.is_mem) begin
            bus.mem_req_addr  = v.addr;
            bus.mem_req_len   = v.len;
            bus.mem_req_size  = v.size;
            bus.mem_req_we    = v.we;
            bus.mem_req_wdata = v.wdata;
            bus.mem_req_valid = 1'b1;
        end else begin
            bus.if_req_addr  = v.addr;
            bus.if_req_len   = v.len;
            bus.if_req_size  = v.size;
            bus.if_req_valid = 1'b1;
        end
    endtask

    task automatic issue(input vec_t v, input string tag);
        logic a;
        logic b;
        set_req(v);
        wait_grant(a, b);
        check({tag, "_grant"}, {b, a}, v.is_mem ? 2'b10 : 2'b01);
        @(posedge clk);
        #1;
        if (v.is_mem) bus.mem_req_valid = 1'b0;
        else bus.if_req_valid = 1'b0;
    endtask

    task automatic wait_bridge(input bit is_write, input string tag, output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (is_write ? bus.cpu_aw_valid : bus.cpu_ar_valid) ok = 1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_bridge_timeout: got no cpu valid, expected one within 50 cycles", tag);
        end
    endtask

    task automatic bridge_read(input vec_t v, input string tag);
        bit ok;
        exp_t e;
        wait_bridge(1'b0, tag, ok);
        if (ok) begin
            check({tag, "_addr"}, bus.cpu_addr, v.addr);
            check({tag, "_len"}, bus.cpu_len, v.exp_len);
            check({tag, "_size"}, bus.cpu_size, v.size);
            repeat (v.delay) begin
                @(negedge clk);
                check({tag, "_ar_hold"}, bus.cpu_ar_valid, 1'b1);
            end
            @(posedge clk);
            #1 bus.cpu_ar_ready = 1'b1;
            @(posedge clk);
            #1 bus.cpu_ar_ready = 1'b0;
            @(negedge clk);
            check({tag, "_ar_drop"}, bus.cpu_ar_valid, 1'b0);
            for (int b = 0; b <= int'(v.len); b++) begin
                @(posedge clk);
                #1 bus.cpu_r_valid = 1'b0;
                repeat (v.gap) begin
                    @(posedge clk);
                    #1;
                end
                bus.cpu_r_valid = 1'b1;
                bus.cpu_r_data  = v.rdata + 64'(b);
                bus.cpu_resp    = (b == 0) ? v.resp : 2'b00;
                e.owner = v.is_mem;
                e.data  = bus.cpu_r_data;
                e.resp  = bus.cpu_resp;
                e.last  = (b == int'(v.len));
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            bus.cpu_r_valid = 1'b0;
            bus.cpu_resp    = 2'b00;
        end
    endtask

    task automatic bridge_write(input vec_t v, input string tag);
        bit ok;
        exp_t e;
        wait_bridge(1'b1, tag, ok);
        if (ok) begin
            check({tag, "_addr"}, bus.cpu_addr, v.addr);
            check({tag, "_wdata"}, bus.cpu_data, v.wdata);
            check({tag, "_len"}, bus.cpu_len, v.exp_len);
            check({tag, "_size"}, bus.cpu_size, v.size);
            repeat (v.delay) begin
                @(negedge clk);
                check({tag, "_aw_hold"}, bus.cpu_aw_valid, 1'b1);
            end
            @(posedge clk);
            #1;
            bus.cpu_aw_ready = 1'b1;
            bus.cpu_resp     = v.resp;
            e.owner = 1'b1;
            e.data  = 64'h0;
            e.resp  = v.resp;
            e.last  = 1'b1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.cpu_aw_ready = 1'b0;
            bus.cpu_resp     = 2'b00;
            @(negedge clk);
            check({tag, "_aw_drop"}, bus.cpu_aw_valid, 1'b0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        issue(v, tag);
        if (v.is_mem && v.we) bridge_write(v, tag);
        else bridge_read(v, tag);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, {bus.mem_req_ready, bus.if_req_ready}, 2'b00);
        check({tag, "_cpu_valid"}, {bus.cpu_aw_valid, bus.cpu_ar_valid}, 2'b00);
        check({tag, "_cpu_addr"}, bus.cpu_addr, 64'h0);
        check({tag, "_cpu_len_size"}, {bus.cpu_len, bus.cpu_size}, 10'h0);
        check({tag, "_cpu_data"}, bus.cpu_data, 64'h0);
        check({tag, "_rsp_valid"}, {bus.mem_rsp_valid, bus.if_rsp_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req_valid = 0; bus.if_req_addr = 0; bus.if_req_len = 0; bus.if_req_size = 0;
        bus.mem_req_valid = 0; bus.mem_req_addr = 0; bus.mem_req_len = 0; bus.mem_req_size = 0;
        bus.mem_req_we = 0; bus.mem_req_wdata = 0;
        bus.cpu_ar_ready = 0; bus.cpu_r_valid = 0; bus.cpu_r_data = 0; bus.cpu_resp = 0;
        bus.cpu_aw_ready = 0;

        vecs[0] = '{1'b0, 1'b0, 64'h8000_0000, 8'd0, 2'd2, 64'h0, 64'h13, 2'b00, 2, 0, 8'd0};
        vecs[1] = '{1'b1, 1'b1, 64'h8000_1000, 8'd5, 2'd3, 64'hDEAD_BEEF, 64'h0, 2'b00, 3, 0, 8'd0};
        vecs[2] = '{1'b0, 1'b0, 64'h8000_0100, 8'd3, 2'd2, 64'h0, 64'h100, 2'b00, 1, 1, 8'd3};
        vecs[3] = '{1'b1, 1'b0, 64'h8000_2000, 8'd1, 2'd3, 64'h0, 64'hA000, 2'b10, 0, 0, 8'd1};
        vecs[4] = '{1'b1, 1'b1, 64'h8000_3008, 8'd0, 2'd1, 64'h1234_5678_9ABC_DEF0, 64'h0, 2'b11,
                    0, 0, 8'd0};
        vecs[5] = '{1'b0, 1'b0, 64'h8000_0200, 8'd7, 2'd3, 64'h0, 64'hF00, 2'b01, 0, 2, 8'd7};
        vm = '{1'b1, 1'b0, 64'h8000_4000, 8'd0, 2'd3, 64'h0, 64'h4444, 2'b00, 0, 0, 8'd0};
        vi = '{1'b0, 1'b0, 64'h8000_5000, 8'd1, 2'd2, 64'h0, 64'h5550, 2'b00, 1, 0, 8'd1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Simultaneous requests alternate, starting with MEM.
        set_req(vm);
        set_req(vi);
        wait_grant(gi, gm);
        check("arb_first_mem", {gm, gi}, 2'b10);
        @(posedge clk);
        #1 bus.mem_req_valid = 1'b0;
        bridge_read(vm, "arb1");
        wait_grant(gi, gm);
        check("arb_second_if", {gm, gi}, 2'b01);
        @(posedge clk);
        #1 bus.if_req_valid = 1'b0;
        bridge_read(vi, "arb2");
        set_req(vm);
        set_req(vi);
        wait_grant(gi, gm);
        check("arb_third_mem", {gm, gi}, 2'b10);
        @(posedge clk);
        #1 bus.mem_req_valid = 1'b0;
        bridge_read(vm, "arb3");
        wait_grant(gi, gm);
        check("arb_fourth_if", {gm, gi}, 2'b01);
        @(posedge clk);
        #1 bus.if_req_valid = 1'b0;
        bridge_read(vi, "arb4");

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Bridge strobes while idle must not produce responses.
        @(posedge clk);
        #1;
        bus.cpu_r_valid  = 1'b1;
        bus.cpu_aw_ready = 1'b1;
        bus.cpu_r_data   = 64'hBAD;
        @(negedge clk);
        check("idle_strobe_rsp", {bus.mem_rsp_valid, bus.if_rsp_valid}, 2'b00);
        @(posedge clk);
        #1;
        bus.cpu_r_valid  = 1'b0;
        bus.cpu_aw_ready = 1'b0;
        @(negedge clk);
        check("idle_strobe_cpu", {bus.cpu_aw_valid, bus.cpu_ar_valid}, 2'b00);

        // Reset during beat 1 of a 3-beat IF burst.
        vi = '{1'b0, 1'b0, 64'h8000_6000, 8'd2, 2'd3, 64'h0, 64'h600, 2'b00, 0, 0, 8'd2};
        issue(vi, "rst");
        @(negedge clk);
        check("rst_ar_valid", bus.cpu_ar_valid, 1'b1);
        @(posedge clk);
        #1 bus.cpu_ar_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_ar_ready = 1'b0;
        bus.cpu_r_valid  = 1'b1;
        bus.cpu_r_data   = 64'h600;
        sb.push_back('{1'b0, 64'h600, 2'b00, 1'b0});
        @(posedge clk);
        #1;
        bus.cpu_r_data = 64'h601;
        sb.push_back('{1'b0, 64'h601, 2'b00, 1'b0});
        reset_n = 1'b0;
        @(posedge clk);
        #1 bus.cpu_r_valid = 1'b0;
        @(negedge clk);
        check_idle("rst_mid");
        @(posedge clk);
        #1 reset_n = 1'b1;
        run_vec(vecs[0], "post_rst");

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
